// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared widths and dispatcher state encoding for the sqrt dispatcher
package sqrt_pkg;

    localparam int OPERAND_W = 16;
    localparam int ROOT_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } disp_state_t;

endpackage

// File: rtl/sqrt_op_fifo.sv
// rtl/sqrt_op_fifo.sv - operand FIFO, DEPTH entries (power of two) of WIDTH bits
// Ports: clk, rst (async, active-high); push/wdata write the tail when not full;
//        pop retires the head when not empty; rdata shows the head;
//        full, empty, count report occupancy.
module sqrt_op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Payload storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers are DEPTH-sized counters, so natural overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_dispatcher.sv
// rtl/sqrt_dispatcher.sv - queues operands and issues them one at a time to a sqrt core
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data operand input;
//        sq_start/sq_in to the core, sq_out/sq_error/sq_done from it;
//        res_valid/res_ready handshake with res_root, res_error, res_timeout, res_operand;
//        pending = FIFO occupancy, busy = work queued or in flight.
// Option: SQRT_NEG_BYPASS_EN answers operands with bit 15 set locally (error, no core call).
module sqrt_dispatcher
    import sqrt_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPERAND_W-1:0]    in_data,
    output logic                    sq_start,
    output logic [OPERAND_W-1:0]    sq_in,
    input  logic [ROOT_W-1:0]       sq_out,
    input  logic                    sq_error,
    input  logic                    sq_done,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ROOT_W-1:0]       res_root,
    output logic                    res_error,
    output logic                    res_timeout,
    output logic [OPERAND_W-1:0]    res_operand,
    output logic [$clog2(DEPTH):0]  pending,
    output logic                    busy
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    disp_state_t           state;
    logic [OPERAND_W-1:0]  op_reg;
    logic [TO_W-1:0]       wait_cnt;
    logic [OPERAND_W-1:0]  head;
    logic                  full;
    logic                  empty;
    logic                  pop;

    assign in_ready = !full;
    assign pop      = (state == IDLE) && !empty;

    sqrt_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OPERAND_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && !full),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (pending)
    );

    // All outputs decode registered state, so they are glitch-free and reset at once.
    assign sq_start    = (state == ISSUE);
    assign sq_in       = op_reg;
    assign res_operand = op_reg;
    assign res_valid   = (state == HOLD);
    assign busy        = (state != IDLE) || !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_reg      <= '0;
            wait_cnt    <= '0;
            res_root    <= '0;
            res_error   <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        op_reg <= head;
`ifdef SQRT_NEG_BYPASS_EN
                        if (head[OPERAND_W-1]) begin
                            state       <= HOLD;
                            res_root    <= '0;
                            res_error   <= 1'b1;
                            res_timeout <= 1'b0;
                        end else begin
                            state <= ISSUE;
                        end
`else
                        state <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // A done seen in the first WAIT cycle may be left over from the
                    // previous operand, so it is only trusted from the second cycle.
                    if ((wait_cnt != '0) && sq_done) begin
                        state       <= HOLD;
                        res_root    <= sq_out;
                        res_error   <= sq_error;
                        res_timeout <= 1'b0;
                    end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                        state       <= HOLD;
                        res_root    <= '0;
                        res_error   <= 1'b1;
                        res_timeout <= 1'b1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
